mux_scan_sequencer: RTL



---
 rtl/mux_scan_pkg.sv | 16 +
 rtl/mux4_to_1.sv | 21 ++
 rtl/mux_scan_timer.sv | 26 ++
 rtl/mux_scan_sequencer.sv | 99 +++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller: FSM state encoding,
// channel count and settle-timer width.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_CH  = 4;
  localparam logic [1:0]  LAST_CH = 2'd3;
  localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/mux4_to_1.sv
// Plain 4-to-1 multiplexer driven by the scan controller (S1 is the MSB select).
module mux4_to_1 (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic s1,
  input  logic s0,
  output logic out
);

  always_comb begin
    unique case ({s1, s0})
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/mux_scan_timer.sv
// Settle down-counter for the mux scan controller; holds at zero once expired.
module mux_scan_timer
  import mux_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans mux channels 0..3, settling SETTLE_CYCLES per channel, and reports a 4-bit word.
// Optional MUX_SCAN_PARITY_EN adds a registered parity output of the final word.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mux_out,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] data
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic              parity
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("mux_scan_sequencer: SETTLE_CYCLES=%0d outside 1..255", SETTLE_CYCLES);
  end

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(SETTLE_CYCLES - 1);

  state_t            state;
  logic              timer_load;
  logic              timer_expired;
  logic [NUM_CH-1:0] data_next;

  assign timer_load = ((state == ST_IDLE) && start) ||
                      ((state == ST_SAMPLE) && (sel != LAST_CH));

  mux_scan_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (RELOAD),
    .expired  (timer_expired)
  );

  always_comb begin
    data_next      = data;
    data_next[sel] = mux_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      data  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sel   <= '0;
            busy  <= 1'b1;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (timer_expired) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          data <= data_next;
          if (sel == LAST_CH) begin
            sel   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            sel   <= sel + 2'd1;
            state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  // data_next already carries the channel-3 sample taken on this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if ((state == ST_SAMPLE) && (sel == LAST_CH)) begin
      parity <= ^data_next;
    end
  end
`endif

endmodule
